fetch_stage: RTL
================

Name: fetch_stage

Overview:
- IF stage plus IF/ID pipeline register; produces InstrD, PCD, PCPlus4D for the decode stage.
- Owns the PC and a single-outstanding-request instruction-memory interface with variable latency.
- Absorbs decode stalls through an internal one-entry hold buffer.
- Accepts taken-branch/jump redirects from EX.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- NOP_INSTR, 32'h0000_0013, instruction driven on InstrD for a bubble (addi x0,x0,0).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- StallD  input  1  hazard unit: hold the IF/ID register.
- PCSrcE  input  1  EX: redirect fetch to PCTargetE.
- PCTargetE  input  32  EX: redirect target.
- imem_req  output  1  request valid.
- imem_addr  output  32  request address.
- imem_ready  input  1  memory accepts the request this cycle.
- imem_rvalid  input  1  response valid; earliest 1 cycle after acceptance.
- imem_rdata  input  32  response instruction.
- InstrD  output  32  IF/ID instruction.
- PCD  output  32  IF/ID PC.
- PCPlus4D  output  32  IF/ID PC+4.
- ValidD  output  1  IF/ID holds a real instruction.
- PCF  output  32  next PC to be requested (debug/trace).

Behaviour:
- Reset (reset==0, async):
  - PCF=RESET_PC; state=REQ; hold buffer empty.
  - InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0.
  - imem_req=0 while reset is asserted.
- States:
  - REQ: imem_req=1, imem_addr=PCF. On imem_ready, latch pc_inflight=PCF and go to WAIT.
  - WAIT: one request outstanding.
  - HOLD: response captured but decode stalled.
  - KILL: outstanding response must be discarded.
- WAIT, imem_rvalid=1, StallD=0, PCSrcE=0:
  - IF/ID <= {imem_rdata, pc_inflight, pc_inflight+4}, ValidD=1.
  - Same cycle: imem_req=1, imem_addr=pc_inflight+4.
  - If ready, pc_inflight <= pc_inflight+4 and stay in WAIT; else PCF <= pc_inflight+4 and go to REQ.
  - Throughput is 1 instr/cycle with a 1-cycle memory.
- WAIT, imem_rvalid=1, StallD=1: capture into hold buffer; go to HOLD; IF/ID unchanged; no request issued.
- HOLD, StallD=0: hold buffer goes into IF/ID (ValidD=1); issue request for held PC+4 (same ready rules as WAIT).
- Bubble rule: StallD=0 and no instruction delivered this cycle -> IF/ID loads InstrD=NOP_INSTR, ValidD=0. PCD and PCPlus4D keep their old values.
- StallD=1 (no redirect): IF/ID holds all fields.
- Redirect (PCSrcE=1) has priority over StallD and over any response:
  - IF/ID flushed to bubble; hold buffer dropped.
  - REQ or HOLD: request PCTargetE immediately (PCF=PCTargetE).
  - WAIT with imem_rvalid this cycle: data dropped; request PCTargetE the same cycle.
  - WAIT without rvalid: PCF <= PCTargetE; go to KILL.
  - KILL: drop the next rvalid, then go to REQ. A new redirect in KILL overwrites PCF only.
- Arithmetic: PC+4 is 32-bit wrap-around (0xFFFF_FFFC -> 0x0000_0000). No other checks unless the optional feature is compiled in.
- imem_req is never asserted while a request is outstanding and its response has not yet arrived.
- Reset mid-WAIT: outstanding response after reset release is ignored. Memory must also be reset; the bench resets both together.

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- With the macro:
  - Adds output InstrMisalignD (1 bit).
  - A redirect with PCTargetE[1:0]!=0 issues no request.
  - The next unstalled cycle loads IF/ID with {NOP_INSTR, PCTargetE, PCTargetE+4}, ValidD=0, InstrMisalignD=1.
  - The FSM then stays in REQ with imem_req=0 until the next redirect.
  - InstrMisalignD clears on any IF/ID load; reset value 0.
- Without the macro: no port; target bits [1:0] are passed to imem_addr unchanged.

Decomposition:
- Shared package: fetch state encoding enum (REQ, WAIT, HOLD, KILL), NOP_INSTR constant, XLEN=32.
- One sub-module: if_id_reg.
  - Purpose: IF/ID pipeline register with stall and flush inputs.
  - Reset values: NOP_INSTR, 0, 0, ValidD=0.

Test Plan:
- Sequential fetch, 1-cycle memory, RESET_PC=0 -> imem_addr 0,4,8,C on consecutive cycles; PCD 0,4,8 one cycle later; ValidD=1 throughout.
- 3-cycle memory latency -> ValidD pattern 1,0,0 repeating (one valid per request); InstrD=NOP_INSTR in bubble cycles.
- StallD=1 for 4 cycles while response at PC 8 arrives -> IF/ID holds PC 4; after StallD=0, PCD=8 with its data; no duplicated or lost instruction.
- PCSrcE=1 with target 0x100 while a request to 0x10 is outstanding -> 0x10 data dropped; next imem_addr=0x100; next ValidD=1 carries PCD=0x100.
- PCSrcE=1 in the same cycle as rvalid and StallD=1 -> IF/ID becomes a bubble; imem_addr=target that cycle.
- reset deasserted then asserted mid-WAIT -> all outputs return to reset values asynchronously; after release, first imem_addr=RESET_PC.
- FETCH_MISALIGN_CHECK_EN, target 0x102 -> no imem_req; InstrMisalignD=1 and PCD=0x102 on the next unstalled cycle.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the fetch stage and its IF/ID register.
// FETCH_MISALIGN_CHECK_EN adds a misalign flag to the IF/ID payload.
package fetch_stage_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    KILL = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic            valid;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic            misalign;
`endif
  } if_id_t;

  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush > stall > load > bubble; bubbles keep the old PC fields.
// FETCH_MISALIGN_CHECK_EN: bubbles also clear the misalign flag.
module if_id_reg import fetch_stage_pkg::*; #(
  parameter logic [XLEN-1:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   stall,
  input  logic   flush,
  input  logic   load,
  input  if_id_t d,
  output if_id_t q
);

  if_id_t q_n;

  always_comb begin
    q_n = q;
    if (flush || !stall) begin
      if (load && !flush) begin
        q_n = d;
      end else begin
        q_n.instr = NOP_INSTR;
        q_n.valid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        q_n.misalign = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q       <= '0;
      q.instr <= NOP_INSTR;
    end else begin
      q <= q_n;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, drives a single-outstanding imem request, feeds IF/ID.
// FETCH_MISALIGN_CHECK_EN: misaligned redirect targets raise InstrMisalignD instead of fetching.
module fetch_stage import fetch_stage_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic            InstrMisalignD,
`endif
  output logic [XLEN-1:0] PCF
);

  fetch_state_e    state, state_n;
  logic [XLEN-1:0] pcf, pcf_n;
  logic [XLEN-1:0] pc_inflight, pc_inflight_n;
  logic [XLEN-1:0] hold_instr, hold_instr_n;
  logic            issue_en;
  logic [XLEN-1:0] issue_addr;
  logic            id_flush, id_load;
  if_id_t          id_d, id_q;
  logic            tgt_bad, req_lock;

`ifdef FETCH_MISALIGN_CHECK_EN
  // Lock parks fetch in REQ after a bad target; pending marks the IF/ID load still owed.
  logic lock_q, lock_n, pend_q, pend_n;

  assign tgt_bad        = PCTargetE[1:0] != 2'b00;
  assign req_lock       = lock_q;
  assign InstrMisalignD = id_q.misalign;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      lock_q <= lock_n;
      pend_q <= pend_n;
    end
  end
`else
  assign tgt_bad  = 1'b0;
  assign req_lock = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= REQ;
      pcf         <= RESET_PC;
      pc_inflight <= RESET_PC;
      hold_instr  <= NOP_INSTR;
    end else begin
      state       <= state_n;
      pcf         <= pcf_n;
      pc_inflight <= pc_inflight_n;
      hold_instr  <= hold_instr_n;
    end
  end

  // Next-state, request and IF/ID control; redirect outranks stall and responses.
  always_comb begin
    state_n       = state;
    pcf_n         = pcf;
    pc_inflight_n = pc_inflight;
    hold_instr_n  = hold_instr;
    issue_en      = 1'b0;
    issue_addr    = pcf;
    id_flush      = 1'b0;
    id_load       = 1'b0;
    id_d          = '0;
    id_d.instr    = NOP_INSTR;
`ifdef FETCH_MISALIGN_CHECK_EN
    lock_n        = lock_q;
    pend_n        = pend_q;
`endif

    if (PCSrcE) begin
      id_flush = 1'b1;
      pcf_n    = PCTargetE;
`ifdef FETCH_MISALIGN_CHECK_EN
      lock_n   = tgt_bad;
      pend_n   = tgt_bad;
`endif
      if ((state == WAIT || state == KILL) && !imem_rvalid) begin
        state_n = KILL;
      end else if (state == KILL) begin
        state_n = REQ;
      end else begin
        state_n    = REQ;
        issue_en   = !tgt_bad;
        issue_addr = PCTargetE;
      end
    end else begin
      case (state)
        REQ: begin
          issue_en   = !req_lock;
          issue_addr = pcf;
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (!StallD) begin
              id_load    = 1'b1;
              id_d.instr = imem_rdata;
              id_d.pc    = pc_inflight;
              id_d.pc4   = pc_plus4(pc_inflight);
              id_d.valid = 1'b1;
              issue_en   = 1'b1;
              issue_addr = pc_plus4(pc_inflight);
            end else begin
              hold_instr_n = imem_rdata;
              state_n      = HOLD;
            end
          end
        end
        HOLD: begin
          if (!StallD) begin
            id_load    = 1'b1;
            id_d.instr = hold_instr;
            id_d.pc    = pc_inflight;
            id_d.pc4   = pc_plus4(pc_inflight);
            id_d.valid = 1'b1;
            issue_en   = 1'b1;
            issue_addr = pc_plus4(pc_inflight);
          end
        end
        KILL: begin
          if (imem_rvalid) state_n = REQ;
        end
      endcase
`ifdef FETCH_MISALIGN_CHECK_EN
      if (pend_q && !StallD) begin
        id_load       = 1'b1;
        id_d.instr    = NOP_INSTR;
        id_d.pc       = pcf;
        id_d.pc4      = pc_plus4(pcf);
        id_d.valid    = 1'b0;
        id_d.misalign = 1'b1;
        pend_n        = 1'b0;
      end
`endif
    end

    if (issue_en) begin
      if (imem_ready) begin
        pc_inflight_n = issue_addr;
        state_n       = WAIT;
      end else begin
        pcf_n   = issue_addr;
        state_n = REQ;
      end
    end
  end

  assign imem_req  = issue_en & reset;
  assign imem_addr = issue_addr;
  assign PCF       = pcf;
  assign InstrD    = id_q.instr;
  assign PCD       = id_q.pc;
  assign PCPlus4D  = id_q.pc4;
  assign ValidD    = id_q.valid;

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk  (clk),
    .reset(reset),
    .stall(StallD),
    .flush(id_flush),
    .load (id_load),
    .d    (id_d),
    .q    (id_q)
  );

endmodule
